// File: rtl/rr_mux_n.sv
// N-channel registered multiplexer with valid/ready on every port.
// Selects by fixed index or round-robin, buffers one word, counts output transfers.
module rr_mux_n #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(N),
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic [SEL_W-1:0]     out_sel,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     out_count
);

    localparam int PAD_N = 2 ** SEL_W;

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [PAD_N-1:0] vld_pad;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W:0]   cand;
    logic [WIDTH-1:0] grant_data;
    logic             accept;
    logic             take;

    // Padding to a power of two lets an out-of-range sel read a zero valid bit.
    always_comb begin
        vld_pad          = '0;
        vld_pad[N-1:0]   = in_valid;
    end

    // Round-robin scans from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (mode) begin
            for (int i = N - 1; i >= 0; i--) begin
                cand = {1'b0, rr_ptr_q} + (SEL_W + 1)'(i);
                if (cand >= (SEL_W + 1)'(N)) begin
                    cand = cand - (SEL_W + 1)'(N);
                end
                if (vld_pad[cand[SEL_W-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand[SEL_W-1:0];
                end
            end
        end else begin
            if (({1'b0, sel} < (SEL_W + 1)'(N)) && vld_pad[sel]) begin
                grant_vld = 1'b1;
                grant_idx = sel;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_idx == SEL_W'(k)) begin
                grant_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = !valid_q || out_ready;
    assign take   = accept && grant_vld;

    always_comb begin
        in_ready = '0;
        for (int k = 0; k < N; k++) begin
            in_ready[k] = !rst && take && (grant_idx == SEL_W'(k));
        end
    end

    always_comb begin
        data_d   = data_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        valid_d  = take || (valid_q && !out_ready);
        count_d  = count_q;
        if (take) begin
            data_d = grant_data;
            sel_d  = grant_idx;
            if (mode) begin
                rr_ptr_d = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + SEL_W'(1);
            end
        end
        if (valid_q && out_ready) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q   <= '0;
            valid_q  <= 1'b0;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_sel   = sel_q;
    assign out_count = count_q;

endmodule
